// File: rtl/flash_read_ctrl.sv
// Fetch stage: turns fetch edges into Avalon-MM flash reads and returns one 32-bit word per request.
// Optional next-word prefetch buffer is enabled with `define FLASH_PREFETCH_EN.
module flash_read_ctrl #(
  parameter int          ADDR_W   = 23,
  parameter logic [31:0] MAX_ADDR = 32'h7FFFF,
  parameter int          DATA_W   = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fetch,
  input  logic [31:0]       address,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              busy,
  output logic              flash_mem_read,
  input  logic              flash_mem_waitrequest,
  output logic [ADDR_W-1:0] flash_mem_address,
  output logic [3:0]        flash_mem_byteenable,
  input  logic [DATA_W-1:0] flash_mem_readdata,
  input  logic              flash_mem_readdatavalid
);
  localparam logic [ADDR_W-1:0] MAX_A = MAX_ADDR[ADDR_W-1:0];

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    DONE    = 3'd3
`ifdef FLASH_PREFETCH_EN
    ,
    PF_REQ  = 3'd4,
    PF_WAIT = 3'd5
`endif
  } state_t;

  state_t            state_q, state_d;
  logic              fetch_q, req;
  logic              pend;
  logic [ADDR_W-1:0] pend_addr, cur_addr, addr_eff, go_addr;
  logic              accept, go, hit;

  assign req      = fetch & ~fetch_q;
  assign addr_eff = (address > MAX_ADDR) ? MAX_A : address[ADDR_W-1:0];

  // A new read may start from IDLE, or straight out of DONE; pending wins over a fresh edge.
  assign accept  = (state_q == IDLE) || (state_q == DONE);
  assign go      = accept & (pend | req);
  assign go_addr = pend ? pend_addr : addr_eff;

`ifdef FLASH_PREFETCH_EN
  logic              buf_vld;
  logic [DATA_W-1:0] pf_buf;
  logic [ADDR_W-1:0] nxt_addr;

  assign nxt_addr = (cur_addr == MAX_A) ? '0 : cur_addr + ADDR_W'(1);
  // cur_addr still names the buffered word while idle after a prefetch
  assign hit      = (state_q == IDLE) & buf_vld & (go_addr == cur_addr);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      buf_vld <= 1'b0;
      pf_buf  <= '0;
    end else if (state_q == PF_WAIT && flash_mem_readdatavalid) begin
      buf_vld <= 1'b1;
      pf_buf  <= flash_mem_readdata;
    end else if (go) begin
      buf_vld <= 1'b0;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = hit ? DONE : REQ;
      REQ:     if (!flash_mem_waitrequest) state_d = WAIT;
      WAIT:    if (flash_mem_readdatavalid) state_d = DONE;
      DONE:
`ifdef FLASH_PREFETCH_EN
               state_d = go ? REQ : PF_REQ;
      PF_REQ:  if (!flash_mem_waitrequest) state_d = PF_WAIT;
      PF_WAIT: if (flash_mem_readdatavalid) state_d = IDLE;
`else
               state_d = go ? REQ : IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flash_mem_read = 1'b0;
    data_valid     = 1'b0;
    busy           = 1'b0;
    case (state_q)
      REQ:     begin flash_mem_read = 1'b1; busy = 1'b1; end
      WAIT:    busy = 1'b1;
      DONE:    data_valid = 1'b1;
`ifdef FLASH_PREFETCH_EN
      PF_REQ:  begin flash_mem_read = 1'b1; busy = pend; end
      PF_WAIT: busy = pend;
`endif
      default: busy = pend;
    endcase
  end

  assign flash_mem_address    = cur_addr;
  assign flash_mem_byteenable = 4'b1111;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_q   <= 1'b0;
      pend      <= 1'b0;
      pend_addr <= '0;
      cur_addr  <= '0;
      data      <= '0;
    end else begin
      fetch_q <= fetch;
      // an edge that is not taken directly is parked; newest address overwrites
      if (req && !(go && !pend)) begin
        pend      <= 1'b1;
        pend_addr <= addr_eff;
      end else if (go) begin
        pend <= 1'b0;
      end
      if (go) cur_addr <= go_addr;
`ifdef FLASH_PREFETCH_EN
      else if (state_q == DONE) cur_addr <= nxt_addr;
      if (hit) data <= pf_buf;
`endif
      if (state_q == WAIT && flash_mem_readdatavalid) data <= flash_mem_readdata;
    end
  end
endmodule

// File: tb/tb_flash_read_ctrl.sv
// Directed bench for flash_read_ctrl; a small Avalon responder returns 0xA5A5_5A5A + (addr - 0x10).
module tb_flash_read_ctrl;
  logic        clock, reset_n, fetch;
  logic [31:0] address, data;
  logic        data_valid, busy, flash_mem_read, flash_mem_waitrequest;
  logic [22:0] flash_mem_address;
  logic [3:0]  flash_mem_byteenable;
  logic [31:0] flash_mem_readdata;
  logic        flash_mem_readdatavalid;

  int nvec = 0, nerr = 0;
  int stall_n = 0, nacc = 0, n0;
  logic inj = 1'b0;

  flash_read_ctrl dut (
    .clock(clock), .reset_n(reset_n), .fetch(fetch), .address(address),
    .data(data), .data_valid(data_valid), .busy(busy),
    .flash_mem_read(flash_mem_read), .flash_mem_waitrequest(flash_mem_waitrequest),
    .flash_mem_address(flash_mem_address), .flash_mem_byteenable(flash_mem_byteenable),
    .flash_mem_readdata(flash_mem_readdata), .flash_mem_readdatavalid(flash_mem_readdatavalid)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Responder: stall_n waitrequest cycles per read, readdatavalid one cycle after acceptance.
  initial begin
    logic        acc_s, inj_s;
    logic [22:0] a_s;
    int          rcnt;
    rcnt = 0;
    flash_mem_waitrequest   = 1'b0;
    flash_mem_readdatavalid = 1'b0;
    flash_mem_readdata      = 32'h0;
    forever begin
      @(posedge clock);
      acc_s = flash_mem_read && !flash_mem_waitrequest;
      a_s   = flash_mem_address;
      inj_s = inj;
      #1;
      if (acc_s) nacc++;
      flash_mem_readdatavalid = acc_s || inj_s;
      flash_mem_readdata = acc_s ? 32'hA5A5_5A5A + ({9'd0, a_s} - 32'h10) : 32'hDEAD_BEEF;
      if (flash_mem_read) begin
        flash_mem_waitrequest = (rcnt < stall_n);
        rcnt++;
      end else begin
        flash_mem_waitrequest = 1'b0;
        rcnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end want end");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0; fetch = 1'b0; address = 32'h0;
    tick(2);
    chk("rst_data", data, 32'h0);
    chk("rst_dv", {31'd0, data_valid}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_read", {31'd0, flash_mem_read}, 32'h0);
    chk("rst_addr", {9'd0, flash_mem_address}, 32'h0);
    chk("byteen", {28'd0, flash_mem_byteenable}, 32'hF);
    reset_n = 1'b1;
    tick(2);

    // basic read
    address = 32'h10; fetch = 1'b1;
    tick();
    chk("basic_read", {31'd0, flash_mem_read}, 32'h1);
    chk("basic_addr", {9'd0, flash_mem_address}, 32'h10);
    chk("basic_busy", {31'd0, busy}, 32'h1);
    tick();
    chk("basic_wait_read", {31'd0, flash_mem_read}, 32'h0);
    tick();
    chk("basic_dv", {31'd0, data_valid}, 32'h1);
    chk("basic_data", data, 32'hA5A5_5A5A);
    chk("basic_busy_done", {31'd0, busy}, 32'h0);
    tick();
    chk("basic_dv_pulse", {31'd0, data_valid}, 32'h0);
    chk("basic_hold", data, 32'hA5A5_5A5A);
    fetch = 1'b0;
    tick(8);

    // stalled read, fetch held high for 20 cycles
    stall_n = 4; n0 = nacc;
    address = 32'h12; fetch = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_hold", {8'd0, flash_mem_read, flash_mem_address}, {8'd0, 1'b1, 23'h12});
    end
    tick();
    chk("stall_rel", {31'd0, flash_mem_read}, 32'h0);
    tick();
    chk("stall_dv", {31'd0, data_valid}, 32'h1);
    chk("stall_data", data, 32'hA5A5_5A5C);
    stall_n = 0;
    tick(13);
`ifdef FLASH_PREFETCH_EN
    chk("one_read", nacc - n0, 32'd2);
`else
    chk("one_read", nacc - n0, 32'd1);
`endif
    fetch = 1'b0;
    tick(8);

    // second edge during WAIT becomes pending
    address = 32'h10; fetch = 1'b1;
    tick();
    chk("pend_read1", {31'd0, flash_mem_read}, 32'h1);
    fetch = 1'b0;
    tick();
    address = 32'h11; fetch = 1'b1;
    tick();
    chk("pend_dv1", {31'd0, data_valid}, 32'h1);
    chk("pend_data1", data, 32'hA5A5_5A5A);
    tick();
    chk("pend_read2", {8'd0, flash_mem_read, flash_mem_address}, {8'd0, 1'b1, 23'h11});
    chk("pend_dv_gap", {31'd0, data_valid}, 32'h0);
    tick(2);
    chk("pend_dv2", {31'd0, data_valid}, 32'h1);
    chk("pend_data2", data, 32'hA5A5_5A5B);
    fetch = 1'b0;
    tick(8);

    // clamp above MAX_ADDR
    address = 32'h0009_0000; fetch = 1'b1;
    tick();
    chk("clamp_addr", {9'd0, flash_mem_address}, 32'h7FFFF);
    tick(2);
    chk("clamp_data", data, 32'hA5AD_5A49);
`ifdef FLASH_PREFETCH_EN
    tick();
    chk("pf_wrap_addr", {8'd0, flash_mem_read, flash_mem_address}, {8'd0, 1'b1, 23'h0});
    chk("pf_not_busy", {31'd0, busy}, 32'h0);
`endif
    fetch = 1'b0;
    tick(8);
    address = 32'h0100_0005; fetch = 1'b1;
    tick();
    chk("clamp_hi_addr", {9'd0, flash_mem_address}, 32'h7FFFF);
    fetch = 1'b0;
    tick(10);

`ifdef FLASH_PREFETCH_EN
    address = 32'h20; fetch = 1'b1;
    tick(3);
    chk("pf_base_data", data, 32'hA5A5_5A6A);
    fetch = 1'b0;
    tick(5);
    n0 = nacc;
    address = 32'h21; fetch = 1'b1;
    tick();
    chk("pf_hit_dv", {31'd0, data_valid}, 32'h1);
    chk("pf_hit_data", data, 32'hA5A5_5A6B);
    chk("pf_hit_noread", nacc - n0, 32'd0);
    fetch = 1'b0;
    tick(6);
    address = 32'h1F; fetch = 1'b1;
    tick();
    chk("pf_miss_read", {8'd0, flash_mem_read, flash_mem_address}, {8'd0, 1'b1, 23'h1F});
    chk("pf_miss_nodv", {31'd0, data_valid}, 32'h0);
    tick(2);
    chk("pf_miss_data", data, 32'hA5A5_5A69);
    fetch = 1'b0;
    tick(8);
`endif

    // reset in the middle of a stalled read
    stall_n = 10;
    address = 32'h30; fetch = 1'b1;
    tick();
    chk("rr_read", {31'd0, flash_mem_read}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("rr_read_drop", {31'd0, flash_mem_read}, 32'h0);
    chk("rr_busy_drop", {31'd0, busy}, 32'h0);
    chk("rr_dv_drop", {31'd0, data_valid}, 32'h0);
    fetch = 1'b0; stall_n = 0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("rr_data_zero", data, 32'h0);
    inj = 1'b1;
    tick();
    inj = 1'b0;
    tick(2);
    chk("rr_late_rdv", data, 32'h0);
    chk("rr_late_dv", {31'd0, data_valid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
